mult_share_arb: RTL and testbench

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

---
 rtl/mult_share_arb.sv | 114 +++++++++++
 tb/tb_mult_share_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
`timescale 1ns/1ps
// Two-requester round-robin front end for one shared repeated-add multiplier,
// with a watchdog that abandons an operation whose ready never returns.
module mult_share_arb #(
   parameter int unsigned data_width = 8
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic [1:0]              req,
   input  logic [data_width-1:0]   A0,
   input  logic [data_width-1:0]   B0,
   input  logic [data_width-1:0]   A1,
   input  logic [data_width-1:0]   B1,
   output logic [1:0]              ack,
   output logic [1:0]              done,
   output logic [2*data_width-1:0] P,
   output logic                    err,
   output logic                    busy,
   output logic                    mult_start,
   output logic [data_width-1:0]   mult_A,
   output logic [data_width-1:0]   mult_B,
   input  logic                    mult_rdy,
   input  logic [2*data_width-1:0] mult_P
);

   localparam int unsigned cnt_w = data_width + 2;
   localparam logic [cnt_w-1:0] cnt_limit = (cnt_w'(1) << data_width) + cnt_w'(2);

   typedef enum logic [1:0] {
      S_idle   = 2'd0,
      S_launch = 2'd1,
      S_wait   = 2'd2,
      S_done   = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic             last, owner;
   logic             winner_c, launch_c;
   logic [cnt_w-1:0] cnt, cnt_nxt;

   // On a tie the requester that was not served last wins.
   assign winner_c = (req[0] & req[1]) ? ~last : req[1];
   // Launch is gated by rst_b so the combinational handshake stays quiet in reset.
   assign launch_c = rst_b & (state == S_idle) & mult_rdy & (|req);

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      ack        = 2'b00;
      mult_start = 1'b0;
      mult_A     = '0;
      mult_B     = '0;
      case (state)
         S_idle: begin
            if (launch_c) begin
               state_nxt  = S_launch;
               mult_start = 1'b1;
               ack        = winner_c ? 2'b10 : 2'b01;
               mult_A     = winner_c ? A1 : A0;
               mult_B     = winner_c ? B1 : B0;
            end
         end
         S_launch: begin
            state_nxt = S_wait;
            cnt_nxt   = '0;
         end
         S_wait: begin
            // Timeout wins over a ready that shows up in the same cycle.
            if (cnt == cnt_limit) begin
               state_nxt = S_idle;
            end else if (mult_rdy) begin
               state_nxt = S_done;
            end else begin
               cnt_nxt = cnt + cnt_w'(1);
            end
         end
         S_done: begin
            state_nxt = S_idle;
         end
         default: begin
            state_nxt = S_idle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= S_idle;
         cnt   <= '0;
         last  <= 1'b1;
         owner <= 1'b0;
         P     <= '0;
         done  <= 2'b00;
         err   <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         busy  <= (state_nxt != S_idle);
         err   <= (state_nxt == S_wait) && (cnt_nxt == cnt_limit);
         done  <= (state_nxt == S_done) ? (owner ? 2'b10 : 2'b01) : 2'b00;
         if (launch_c) begin
            owner <= winner_c;
         end
         if ((state == S_wait) && (state_nxt == S_done)) begin
            P <= mult_P;
         end
         if (state == S_done) begin
            last <= owner;
         end
      end
   end

endmodule

// File: tb/tb_mult_share_arb.sv
`timescale 1ns/1ps
// Bench for mult_share_arb: behavioural multiplier plus a requester-level
// model of grants, products and latency.
module tb_mult_share_arb;

   localparam int unsigned dw = 8;

   logic          clk = 1'b0;
   logic          rst_b = 1'b0;
   logic [1:0]    req = 2'b00;
   logic [dw-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
   logic [1:0]    ack, done;
   logic [2*dw-1:0] P;
   logic          err, busy, mult_start;
   logic [dw-1:0] mult_A, mult_B;
   logic          m_rdy;
   logic [2*dw-1:0] m_prod;
   logic [dw-1:0] m_cnt;
   bit            stuck = 1'b0;

   mult_share_arb #(.data_width(dw)) dut (
      .clk(clk), .rst_b(rst_b), .req(req),
      .A0(A0), .B0(B0), .A1(A1), .B1(B1),
      .ack(ack), .done(done), .P(P), .err(err), .busy(busy),
      .mult_start(mult_start), .mult_A(mult_A), .mult_B(mult_B),
      .mult_rdy(m_rdy), .mult_P(m_prod)
   );

   always #10 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Repeated-add multiplier: ready drops after start, returns a+1 cycles later.
   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         m_rdy <= 1'b1; m_cnt <= '0; m_prod <= '0;
      end else if (m_rdy && mult_start) begin
         m_rdy <= 1'b0; m_cnt <= mult_A; m_prod <= 16'(mult_A) * 16'(mult_B);
      end else if (!m_rdy && !stuck) begin
         if (m_cnt == 0) m_rdy <= 1'b1;
         else m_cnt <= m_cnt - 8'd1;
      end
   end

   int n_checks = 0, n_fail = 0;
   int exp_last = 1;
   int exp_p = 0;
   int op_a[2], op_b[2];

   // Event log, sampled late in each cycle; requesters drop req after their ack.
   int ack_cnt = 0, done_cnt = 0, err_cnt = 0, viol = 0;
   int ack_cyc, ack_idx, done_cyc, done_idx, err_cyc;
   logic [dw-1:0] ack_a, ack_b;
   logic [2*dw-1:0] done_p;
   logic [1:0] drop = 2'b00;

   always begin
      @(negedge clk);
      req = req & ~drop;
      drop = 2'b00;
      #8;
      if ((int'(ack != 0) + int'(done != 0) + int'(err)) > 1) viol++;
      if (!mult_start && (mult_A != 0 || mult_B != 0)) viol++;
      if (mult_start != (ack != 0)) viol++;
      if (ack == 2'b11 || done == 2'b11) viol++;
      if (ack != 0) begin
         ack_cnt++; ack_cyc = cyc; ack_idx = ack[1] ? 1 : 0;
         ack_a = mult_A; ack_b = mult_B; drop = ack;
      end
      if (done != 0) begin
         done_cnt++; done_cyc = cyc; done_idx = done[1] ? 1 : 0; done_p = P;
      end
      if (err) begin
         err_cnt++; err_cyc = cyc;
      end
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   function automatic int exp_winner(input logic [1:0] r, input int last);
      if (r == 2'b01) return 0;
      if (r == 2'b10) return 1;
      return (last == 1) ? 0 : 1;
   endfunction

   task automatic set_req(input int idx, input logic [dw-1:0] a, input logic [dw-1:0] b);
      op_a[idx] = int'(a); op_b[idx] = int'(b);
      if (idx == 0) begin A0 = a; B0 = b; req[0] = 1'b1; end
      else begin A1 = a; B1 = b; req[1] = 1'b1; end
   endtask

   // Waits for the next done or err event; to=1 if the budget runs out.
   task automatic serve_one(input int budget, output bit to);
      int d0 = done_cnt;
      int e0 = err_cnt;
      to = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk); #9;
         if (done_cnt != d0 || err_cnt != e0) begin to = 1'b0; break; end
      end
   endtask

   task automatic test_reset();
      rst_b = 1'b0; req = 2'b00;
      repeat (3) @(negedge clk);
      #8;
      n_checks++;
      if ({ack, done, err, busy, mult_start} !== 7'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b required 0", {ack, done, err, busy, mult_start});
      end
      n_checks++;
      if (P !== '0) begin n_fail++; $display("FAIL reset_P: got %0d required 0", P); end
      @(negedge clk); #1; rst_b = 1'b1;
      exp_last = 1; exp_p = 0;
   endtask

   task automatic test_tie();
      bit to;
      int w, prev_done;
      @(negedge clk); #1;
      set_req(0, 8'd2, 8'd7); set_req(1, 8'd4, 8'd9);
      for (int k = 0; k < 4; k++) begin
         if (k == 2) begin
            @(negedge clk); #1;
            set_req(0, 8'd2, 8'd7); set_req(1, 8'd4, 8'd9);
         end
         w = exp_winner(req, exp_last);
         serve_one(100, to);
         n_checks++;
         if (to || ack_idx !== w || done_idx !== w) begin
            n_fail++; $display("FAIL tie_grant%0d: got ack %0d done %0d timeout %0d required %0d", k, ack_idx, done_idx, to, w);
         end
         n_checks++;
         if (done_p !== 16'(op_a[w] * op_b[w])) begin
            n_fail++; $display("FAIL tie_P%0d: got %0d required %0d", k, done_p, op_a[w] * op_b[w]);
         end
         if (k > 0) begin
            n_checks++;
            if (ack_cyc !== prev_done + 1) begin
               n_fail++; $display("FAIL tie_b2b%0d: got ack cycle %0d required %0d", k, ack_cyc, prev_done + 1);
            end
         end
         prev_done = done_cyc; exp_last = w; exp_p = op_a[w] * op_b[w];
      end
   endtask

   task automatic test_single();
      bit to;
      int a0 = ack_cnt;
      @(negedge clk); #1;
      set_req(0, 8'd3, 8'd5);
      serve_one(100, to);
      n_checks++;
      if (to || ack_cnt !== a0 + 1 || ack_idx !== 0 || done_idx !== 0) begin
         n_fail++; $display("FAIL single_grant: got acks %0d idx %0d/%0d timeout %0d required 1 idx 0", ack_cnt - a0, ack_idx, done_idx, to);
      end
      n_checks++;
      if (ack_a !== 8'd3 || ack_b !== 8'd5) begin
         n_fail++; $display("FAIL single_operands: got %0d,%0d required 3,5", ack_a, ack_b);
      end
      n_checks++;
      if (done_cyc - ack_cyc !== 6) begin
         n_fail++; $display("FAIL single_latency: got %0d required 6", done_cyc - ack_cyc);
      end
      n_checks++;
      if (done_p !== 16'd15) begin n_fail++; $display("FAIL single_P: got %0d required 15", done_p); end
      @(negedge clk); #9;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b required 0", busy); end
      exp_last = 0; exp_p = 15;
   endtask

   task automatic test_zero_max();
      bit to;
      int idx[3] = '{0, 0, 1};
      int av[3]  = '{0, 200, 255};
      int bv[3]  = '{200, 0, 255};
      int e0 = err_cnt;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         set_req(idx[k], 8'(av[k]), 8'(bv[k]));
         serve_one(400, to);
         n_checks++;
         if (to || done_idx !== idx[k]) begin
            n_fail++; $display("FAIL zmax_grant%0d: got idx %0d timeout %0d required %0d", k, done_idx, to, idx[k]);
         end
         n_checks++;
         if (done_cyc - ack_cyc !== 3 + av[k]) begin
            n_fail++; $display("FAIL zmax_latency%0d: got %0d required %0d", k, done_cyc - ack_cyc, 3 + av[k]);
         end
         n_checks++;
         if (done_p !== 16'(av[k] * bv[k])) begin
            n_fail++; $display("FAIL zmax_P%0d: got %0d required %0d", k, done_p, av[k] * bv[k]);
         end
         exp_last = idx[k]; exp_p = av[k] * bv[k];
      end
      n_checks++;
      if (err_cnt !== e0) begin n_fail++; $display("FAIL zmax_err: got %0d err pulses required 0", err_cnt - e0); end
   endtask

   task automatic test_pending();
      bit to;
      int d_first;
      @(negedge clk); #1;
      set_req(0, 8'd10, 8'd11);
      repeat (4) @(negedge clk);
      #1;
      set_req(1, 8'd3, 8'd4);
      serve_one(100, to);
      d_first = done_cyc;
      n_checks++;
      if (to || done_idx !== 0 || done_p !== 16'd110) begin
         n_fail++; $display("FAIL pending_first: got idx %0d P %0d timeout %0d required idx 0 P 110", done_idx, done_p, to);
      end
      serve_one(100, to);
      n_checks++;
      if (to || done_idx !== 1 || done_p !== 16'd12 || ack_cyc !== d_first + 1) begin
         n_fail++; $display("FAIL pending_second: got idx %0d P %0d ack %0d timeout %0d required idx 1 P 12 ack %0d", done_idx, done_p, ack_cyc, to, d_first + 1);
      end
      exp_last = 1; exp_p = 12;
   endtask

   task automatic test_random();
      bit to;
      int w;
      for (int it = 0; it < 20; it++) begin
         @(negedge clk); #1;
         for (int i = 0; i < 2; i++)
            if (!req[i] && $urandom_range(0, 1) == 1) set_req(i, 8'($urandom_range(0, 40)), 8'($urandom));
         if (req == 2'b00) set_req(int'($urandom_range(0, 1)), 8'($urandom_range(0, 40)), 8'($urandom));
         w = exp_winner(req, exp_last);
         serve_one(100, to);
         n_checks++;
         if (to || ack_idx !== w || done_idx !== w) begin
            n_fail++; $display("FAIL rand%0d_grant: got ack %0d done %0d timeout %0d required %0d", it, ack_idx, done_idx, to, w);
         end
         n_checks++;
         if (done_p !== 16'(op_a[w] * op_b[w]) || done_cyc - ack_cyc !== 3 + op_a[w]) begin
            n_fail++; $display("FAIL rand%0d_result: got P %0d lat %0d required P %0d lat %0d", it, done_p, done_cyc - ack_cyc, op_a[w] * op_b[w], 3 + op_a[w]);
         end
         exp_last = w; exp_p = op_a[w] * op_b[w];
      end
      while (req != 2'b00) begin
         w = exp_winner(req, exp_last);
         serve_one(100, to);
         n_checks++;
         if (to || done_idx !== w || done_p !== 16'(op_a[w] * op_b[w])) begin
            n_fail++; $display("FAIL rand_drain: got idx %0d P %0d timeout %0d required idx %0d P %0d", done_idx, done_p, to, w, op_a[w] * op_b[w]);
         end
         exp_last = w; exp_p = op_a[w] * op_b[w];
      end
   endtask

   task automatic test_timeout();
      bit to;
      int w;
      int d0 = done_cnt;
      int e0 = err_cnt;
      int last_before = exp_last;
      stuck = 1'b1;
      @(negedge clk); #1;
      set_req(0, 8'd5, 8'd6);
      serve_one(400, to);
      n_checks++;
      if (to || err_cnt !== e0 + 1 || done_cnt !== d0) begin
         n_fail++; $display("FAIL timeout_event: got err %0d done %0d timeout %0d required err 1 done 0", err_cnt - e0, done_cnt - d0, to);
      end
      n_checks++;
      if (err_cyc - ack_cyc !== 260) begin
         n_fail++; $display("FAIL timeout_cycle: got %0d required 260", err_cyc - ack_cyc);
      end
      @(negedge clk); #9;
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b0 || P !== 16'(exp_p)) begin
         n_fail++; $display("FAIL timeout_after: got err %b busy %b P %0d required 0 0 %0d", err, busy, P, exp_p);
      end
      stuck = 1'b0;
      for (int i = 0; i < 20 && !m_rdy; i++) @(negedge clk);
      @(negedge clk); #1;
      set_req(0, 8'd1, 8'd9); set_req(1, 8'd2, 8'd8);
      w = exp_winner(req, last_before);
      serve_one(100, to);
      n_checks++;
      if (to || done_idx !== w || done_p !== 16'(op_a[w] * op_b[w])) begin
         n_fail++; $display("FAIL timeout_last: got idx %0d P %0d timeout %0d required idx %0d", done_idx, done_p, to, w);
      end
      exp_last = w;
      w = exp_winner(req, exp_last);
      serve_one(100, to);
      exp_last = w; exp_p = op_a[w] * op_b[w];
   endtask

   task automatic test_reset_mid();
      bit to;
      int d0, e0;
      @(negedge clk); #1;
      set_req(1, 8'd100, 8'd3);
      repeat (20) @(negedge clk);
      d0 = done_cnt; e0 = err_cnt;
      #2; rst_b = 1'b0; #1;
      n_checks++;
      if ({ack, done, err, busy, mult_start} !== 7'b0 || P !== '0) begin
         n_fail++; $display("FAIL rmid_immediate: got ctrl %b P %0d required 0 0", {ack, done, err, busy, mult_start}, P);
      end
      set_req(0, 8'd6, 8'd7); set_req(1, 8'd5, 8'd2);
      repeat (3) @(negedge clk);
      #8;
      n_checks++;
      if (done_cnt !== d0 || err_cnt !== e0 || ack !== 2'b00) begin
         n_fail++; $display("FAIL rmid_quiet: got done %0d err %0d ack %b required 0 0 00", done_cnt - d0, err_cnt - e0, ack);
      end
      @(negedge clk); #1; rst_b = 1'b1;
      exp_last = 1;
      serve_one(100, to);
      n_checks++;
      if (to || done_idx !== 0 || done_p !== 16'd42) begin
         n_fail++; $display("FAIL rmid_first: got idx %0d P %0d timeout %0d required idx 0 P 42", done_idx, done_p, to);
      end
      serve_one(100, to);
      n_checks++;
      if (to || done_idx !== 1 || done_p !== 16'd10) begin
         n_fail++; $display("FAIL rmid_second: got idx %0d P %0d timeout %0d required idx 1 P 10", done_idx, done_p, to);
      end
   endtask

   task automatic test_protocol();
      @(negedge clk); #9;
      n_checks++;
      if (viol !== 0) begin
         n_fail++; $display("FAIL protocol: got %0d exclusivity/operand violations required 0", viol);
      end
   endtask

   initial begin
      test_reset();
      test_tie();
      test_single();
      test_zero_max();
      test_pending();
      test_random();
      test_timeout();
      test_reset_mid();
      test_protocol();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
